// File: rtl/seg_mux_display.sv
// Binary-to-BCD converter (double dabble) feeding a multiplexed, active-low
// seven-segment display with optional leading-zero blanking and overflow dashes.
module seg_mux_display #(
    parameter int DIGITS   = 4,
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BIN_W-1:0]  bin_in,
    input  logic              load,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg_n,
    output logic [DIGITS-1:0] an_n
);

    function automatic int unsigned pow10(input int n);
        int unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;
    localparam int CNT_W = $clog2(BIN_W);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    typedef enum logic {IDLE, CONV} state_t;

    state_t                   state_q, state_d;
    logic                     start, conv_done;
    logic [BIN_W-1:0]         shift_q;
    logic [4*DIGITS-1:0]      bcd_q, bcd_adj, bcd_next;
    logic [CNT_W-1:0]         cnt_q;
    logic                     ovf_pend_q;
    logic [DIGITS-1:0][3:0]   disp_q;
    logic                     overflow_q;
    logic [PRE_W-1:0]         presc_q;
    logic [IDX_W-1:0]         idx_q;
    logic [6:0]               seg_all [DIGITS];
    logic                     zero_run;
    logic [6:0]               seg_q;
    logic [DIGITS-1:0]        an_q;

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        conv_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    start   = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (cnt_q == CNT_LAST) begin
                    conv_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = (bcd_adj << 1) | {{(4*DIGITS-1){1'b0}}, shift_q[BIN_W-1]};
    end

    // NOTE: sequential state uses non-blocking assignments only; the display
    // register is reset because its cleared value is visible on the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            overflow_q <= 1'b0;
        end else if (start) begin
            shift_q    <= bin_in;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= (32'(bin_in) > MAX_VAL);
        end else if (state_q == CONV) begin
            shift_q <= shift_q << 1;
            bcd_q   <= bcd_next;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (conv_done) begin
                // Display and overflow flag change together, never mid-conversion.
                disp_q     <= bcd_next;
                overflow_q <= ovf_pend_q;
            end
        end
    end

    // ---------------- scan timing ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == PRE_LAST) begin
            presc_q <= '0;
            idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    // Per-digit segment patterns; zero_run tracks "this and all higher digits are 0".
    always_comb begin
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_q[i] == 4'd0);
            if (overflow_q)
                seg_all[i] = SEG_DASH;
            else if ((BLANK_LZ != 0) && (i != 0) && zero_run)
                seg_all[i] = SEG_BLANK;
            else
                seg_all[i] = seg_decode(disp_q[i]);
        end
    end

    // Segments and anode are registered from the same index so they switch together.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= seg_decode(4'd0);
            an_q  <= ~DIGITS'(1);
        end else begin
            seg_q <= seg_all[idx_q];
            an_q  <= ~(DIGITS'(1) << idx_q);
        end
    end

    assign busy     = (state_q == CONV);
    assign overflow = overflow_q;
    assign seg_n    = seg_q;
    assign an_n     = an_q;

endmodule

// File: tb/tb_seg_mux_display.sv
// Self-checking bench for seg_mux_display: directed and random loads compared
// against an arithmetic model of the displayed digits and the scan order.
module tb_seg_mux_display;

    localparam int DIGITS   = 4;
    localparam int BIN_W    = 14;
    localparam int SCAN_DIV = 4;
    localparam int CONV_LEN = BIN_W;

    logic             clk = 1'b0;
    logic             reset;
    logic [BIN_W-1:0] bin_in, bin2;
    logic             load, load2;
    logic             busy, busy2, overflow, overflow2;
    logic [6:0]       seg_n, seg_n2;
    logic [DIGITS-1:0] an_n, an_n2;

    int checks = 0;
    int errors = 0;
    int cyc;

    always #5 clk = ~clk;

    seg_mux_display #(.DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) u_dut (
        .clk(clk), .reset(reset), .bin_in(bin_in), .load(load),
        .busy(busy), .overflow(overflow), .seg_n(seg_n), .an_n(an_n)
    );

    seg_mux_display #(.DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)) u_dut_nb (
        .clk(clk), .reset(reset), .bin_in(bin2), .load(load2),
        .busy(busy2), .overflow(overflow2), .seg_n(seg_n2), .an_n(an_n2)
    );

    // Cycles since the last reset edge: the scan position is a pure function of it.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] digit_pattern(input int dig);
        case (dig)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    // Expected pattern for digit position d when value v is on the display.
    function automatic logic [6:0] exp_seg(input int v, input bit ovf, input int d, input bit blz);
        int p;
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        if (ovf) return 7'h3F;
        if (blz && d != 0 && v < p) return 7'h7F;
        return digit_pattern((v / p) % 10);
    endfunction

    task automatic scan_check(input int inst, input int v, input bit ovf, input bit blz, input int n);
        int d;
        logic [DIGITS-1:0] e_an;
        for (int i = 0; i < n; i++) begin
            d = (cyc == 0) ? 0 : ((cyc - 1) / SCAN_DIV) % DIGITS;
            e_an = ~(DIGITS'(1) << d);
            check($sformatf("an_n[inst%0d,cyc%0d]", inst, cyc),
                  32'(inst == 1 ? an_n : an_n2), 32'(e_an));
            check($sformatf("seg_n[inst%0d,v=%0d,digit%0d]", inst, v, d),
                  32'(inst == 1 ? seg_n : seg_n2), 32'(exp_seg(v, ovf, d, blz)));
            tick();
        end
    endtask

    // Issue one load and count busy cycles; optionally keep load high throughout.
    task automatic run_conv(input int v, input bit hammer, output int busy_cycles);
        bin_in = BIN_W'(v);
        load   = 1'b1;
        tick();
        load = 1'b0;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            if (hammer) begin
                load   = 1'b1;
                bin_in = BIN_W'($urandom);
            end
            tick();
        end
        load = 1'b0;
    endtask

    task automatic load_and_verify(input string tag, input int v);
        int bc;
        run_conv(v, 1'b0, bc);
        check({tag, "_busy_len"}, 32'(bc), 32'(CONV_LEN));
        check({tag, "_overflow"}, 32'(overflow), 32'(v > 9999));
        tick();
        scan_check(1, v, v > 9999, 1'b1, 16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bc, bc2, v, a, b, n;
        reset = 1'b1; load = 1'b0; load2 = 1'b0; bin_in = '0; bin2 = '0;
        tick(); tick(); tick();

        check("rst_an_n", 32'(an_n), 32'hE);
        check("rst_seg_n", 32'(seg_n), 32'h40);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        reset = 1'b0;

        scan_check(1, 0, 1'b0, 1'b1, 20);
        check("idle_busy", 32'(busy), 32'h0);

        load_and_verify("v1234", 1234);
        load_and_verify("v9999", 9999);
        load_and_verify("v10000", 10000);

        // Load held high for the whole conversion: only the first value counts.
        run_conv(7, 1'b1, bc);
        check("hammer_busy_len", 32'(bc), 32'(CONV_LEN));
        tick();
        check("hammer_busy_after", 32'(busy), 32'h0);
        check("hammer_overflow", 32'(overflow), 32'h0);
        scan_check(1, 7, 1'b0, 1'b1, 16);

        for (int r = 0; r < 6; r++) begin
            v = int'($urandom_range(0, 12000));
            load_and_verify($sformatf("rand%0d", r), v);
        end

        // Load accepted in the very cycle busy drops.
        a = int'($urandom_range(0, 9999));
        b = 12345;
        run_conv(a, 1'b0, bc);
        run_conv(b, 1'b0, bc2);
        check("b2b_first_len", 32'(bc), 32'(CONV_LEN));
        check("b2b_second_len", 32'(bc2), 32'(CONV_LEN));
        check("b2b_overflow", 32'(overflow), 32'h1);
        tick();
        scan_check(1, b, 1'b1, 1'b1, 16);

        // Reset in the sixth conversion cycle discards the partial result.
        bin_in = BIN_W'(305);
        load   = 1'b1;
        tick();
        load = 1'b0;
        repeat (5) tick();
        check("abort_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_overflow", 32'(overflow), 32'h0);
        scan_check(1, 0, 1'b0, 1'b1, 24);
        check("abort_busy_late", 32'(busy), 32'h0);

        // Reset wins over a simultaneous load.
        load_and_verify("pre_prio", 4321);
        reset = 1'b1; load = 1'b1; bin_in = BIN_W'(55);
        tick();
        reset = 1'b0; load = 1'b0;
        check("prio_busy", 32'(busy), 32'h0);
        tick();
        check("prio_busy_next", 32'(busy), 32'h0);
        scan_check(1, 0, 1'b0, 1'b1, 16);

        // Instance without leading-zero blanking.
        bin2  = BIN_W'(5);
        load2 = 1'b1;
        tick();
        load2 = 1'b0;
        n = 0;
        while (busy2 === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("nb_busy_len", 32'(n), 32'(CONV_LEN));
        check("nb_overflow", 32'(overflow2), 32'h0);
        tick();
        scan_check(2, 5, 1'b0, 1'b0, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
